seq_bidir_shifter: RTL and testbench

Parametrised, iterative bidirectional shifter. It is the sequential successor to the combinational 8-bit bi-directional shifter.
- Accepts an operand, a shift amount, a direction and a mode on a start pulse.
- Shifts one bit position per clock, then presents a registered result with a one-cycle done pulse.
- Adds arithmetic and rotate modes and a carry (last-bit-out) flag.
- Intended as the shift unit behind the lab ALU datapath.

---
 rtl/seq_bidir_shifter.sv | 140 ++++++++++++++
 tb/tb_seq_bidir_shifter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_bidir_shifter.sv
// Iterative bidirectional shifter: one bit position per clock, with
// logical, arithmetic and rotate modes. Presents a registered result,
// a last-bit-out carry flag and a one-cycle done pulse.
module seq_bidir_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               shift_direction,
  input  logic [1:0]         mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   shifter_out,
  output logic               carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Mode 2'b11 is not decoded and therefore behaves as logical.
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   shifter_out_q, shifter_out_d;
  logic               carry_q, carry_d;

  logic [WIDTH-1:0]   step_work;
  logic               step_bit;
  logic               fill_bit;
  logic               accept;

  // Single-position shift of the work register under the captured controls.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    fill_bit  = 1'b0;
    step_bit  = dir_q ? work_q[0] : work_q[WIDTH-1];
    step_work = work_q;
    if (!dir_q) begin
      if (mode_q == MODE_ROT) begin
        fill_bit = work_q[WIDTH-1];
      end
      step_work = {work_q[WIDTH-2:0], fill_bit};
    end else begin
      if (mode_q == MODE_ROT) begin
        fill_bit = work_q[0];
      end else if (mode_q == MODE_ARITH) begin
        fill_bit = work_q[WIDTH-1];
      end
      step_work = {fill_bit, work_q[WIDTH-1:1]};
    end
  end

  // Next-state, datapath and result update for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    mode_d        = mode_q;
    shifter_out_d = shifter_out_q;
    carry_d       = carry_q;
    accept        = start && (state_q == IDLE || state_q == DONE);

    case (state_q)
      SHIFT: begin
        work_d = step_work;
        cnt_d  = cnt_q - SHAMT_W'(1);
        // Final step: the result is registered together with the last shift.
        if (cnt_q == SHAMT_W'(1)) begin
          shifter_out_d = step_work;
          carry_d       = step_bit;
          state_d       = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Start is honoured in IDLE and DONE, so a DONE cycle can chain directly.
    if (accept) begin
      work_d = d_in;
      cnt_d  = shift_amount;
      dir_d  = shift_direction;
      mode_d = mode;
      if (shift_amount == '0) begin
        shifter_out_d = d_in;
        carry_d       = 1'b0;
        state_d       = DONE;
      end else begin
        state_d = SHIFT;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    if (reset) begin
      state_q       <= IDLE;
      work_q        <= '0;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      mode_q        <= 2'b00;
      shifter_out_q <= '0;
      carry_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      mode_q        <= mode_d;
      shifter_out_q <= shifter_out_d;
      carry_q       <= carry_d;
    end
  end

  assign busy        = (state_q == SHIFT);
  assign done        = (state_q == DONE);
  assign shifter_out = shifter_out_q;
  assign carry_out   = carry_q;

endmodule

// File: tb/tb_seq_bidir_shifter.sv
// Self-checking bench for seq_bidir_shifter (WIDTH=8): a table of directed
// operations plus hand-written back-to-back and reset-abort sequences.
module tb_seq_bidir_shifter;

  localparam int WIDTH   = 8;
  localparam int SHAMT_W = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   d_in;
  logic [SHAMT_W-1:0] shift_amount;
  logic               shift_direction;
  logic [1:0]         mode;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   shifter_out;
  logic               carry_out;

  int checks   = 0;
  int failures = 0;

  seq_bidir_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .d_in            (d_in),
    .shift_amount    (shift_amount),
    .shift_direction (shift_direction),
    .mode            (mode),
    .busy            (busy),
    .done            (done),
    .shifter_out     (shifter_out),
    .carry_out       (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] k;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] exp_out;
    logic       exp_c;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation from IDLE (called at a negedge) and check it.
  task automatic run_op(input int idx, input logic [7:0] d, input logic [2:0] k,
                        input logic dir, input logic [1:0] md,
                        input logic [7:0] exp_out, input logic exp_c);
    logic [7:0] prev_out;
    int         busy_n;
    int         cyc;
    bit         hold_ok;
    prev_out        = shifter_out;
    start           = 1'b1;
    d_in            = d;
    shift_amount    = k;
    shift_direction = dir;
    mode            = md;
    @(negedge clk);
    // Scramble inputs after acceptance; they must have no effect.
    start           = 1'b0;
    d_in            = ~d;
    shift_amount    = ~k;
    shift_direction = ~dir;
    mode            = ~md;
    busy_n  = 0;
    cyc     = 0;
    hold_ok = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) busy_n++;
      if (shifter_out !== prev_out || carry_out === 1'bx) hold_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d done_seen", idx), {31'b0, done}, 32'd1);
    check($sformatf("v%0d busy_cycles", idx), busy_n, {29'b0, k});
    check($sformatf("v%0d out_hold", idx), {31'b0, hold_ok}, 32'd1);
    check($sformatf("v%0d shifter_out", idx), {24'b0, shifter_out}, {24'b0, exp_out});
    check($sformatf("v%0d carry_out", idx), {31'b0, carry_out}, {31'b0, exp_c});
    @(negedge clk);
    check($sformatf("v%0d done_pulse_1cyc", idx), {30'b0, done, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    //        d        k     dir   mode   exp_out  c
    vecs[0]  = '{8'h20, 3'd2, 1'b0, 2'b00, 8'h80, 1'b0}; // left logical
    vecs[1]  = '{8'h10, 3'd3, 1'b1, 2'b00, 8'h02, 1'b0}; // right logical
    vecs[2]  = '{8'h96, 3'd3, 1'b1, 2'b01, 8'hF2, 1'b1}; // arith right
    vecs[3]  = '{8'hC1, 3'd1, 1'b0, 2'b01, 8'h82, 1'b1}; // arith left
    vecs[4]  = '{8'h81, 3'd1, 1'b0, 2'b10, 8'h03, 1'b1}; // rotate left
    vecs[5]  = '{8'h0F, 3'd7, 1'b1, 2'b10, 8'h1E, 1'b0}; // rotate right max k
    vecs[6]  = '{8'h96, 3'd4, 1'b0, 2'b10, 8'h69, 1'b1}; // rotate left 4
    vecs[7]  = '{8'h80, 3'd7, 1'b1, 2'b01, 8'hFF, 1'b0}; // arith right max k
    vecs[8]  = '{8'h40, 3'd2, 1'b0, 2'b11, 8'h00, 1'b1}; // mode 11 left
    vecs[9]  = '{8'hF0, 3'd4, 1'b1, 2'b11, 8'h0F, 1'b0}; // mode 11 right
    vecs[10] = '{8'h01, 3'd1, 1'b1, 2'b00, 8'h00, 1'b1}; // right out of bit0
    vecs[11] = '{8'h3C, 3'd0, 1'b1, 2'b10, 8'h3C, 1'b0}; // zero amount

    reset = 1'b1; start = 1'b0; d_in = '0; shift_amount = '0;
    shift_direction = 1'b0; mode = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_outputs", {22'b0, busy, done, shifter_out, carry_out}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {30'b0, busy, done}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(i, vecs[i].d, vecs[i].k, vecs[i].dir, vecs[i].mode,
             vecs[i].exp_out, vecs[i].exp_c);
    end

    // Zero amount followed by a start held in the DONE cycle.
    start = 1'b1; d_in = 8'hA5; shift_amount = 3'd0; shift_direction = 1'b0; mode = 2'b00;
    @(negedge clk);
    check("b2b_first_done", {30'b0, busy, done}, 32'd1);
    check("b2b_first_out", {23'b0, shifter_out, carry_out}, {23'b0, 8'hA5, 1'b0});
    d_in = 8'h01; shift_amount = 3'd1;
    @(negedge clk);
    start = 1'b0; d_in = 8'hFF;
    check("b2b_second_busy", {30'b0, busy, done}, 32'd2);
    check("b2b_out_held", {24'b0, shifter_out}, 32'hA5);
    @(negedge clk);
    check("b2b_second_done", {30'b0, busy, done}, 32'd1);
    check("b2b_second_out", {23'b0, shifter_out, carry_out}, {23'b0, 8'h02, 1'b0});
    @(negedge clk);

    // Start ignored during SHIFT, then reset aborts the operation.
    start = 1'b1; d_in = 8'h01; shift_amount = 3'd5; shift_direction = 1'b0; mode = 2'b00;
    @(negedge clk);
    d_in = 8'hFF; shift_amount = 3'd0;
    check("abort_busy1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("abort_busy2", {30'b0, busy, done}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_reset_state", {22'b0, busy, done, shifter_out, carry_out}, 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 32'd0);

    // Fresh operation after the abort completes normally.
    run_op(99, 8'h01, 3'd5, 1'b0, 2'b00, 8'h20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
